ram_refresh_sched: RTL and testbench
====================================

# ram_refresh_sched

DRAM refresh scheduler that generates the refresh request and urgent-refresh pair consumed by the RAM controller. It runs a fixed-period refresh timer and keeps a saturating count of owed refreshes. Each owed refresh escalates from request to urgent by age or backlog. It retires one owed refresh per controller acknowledge and guarantees the request-low gap the controller needs to re-arm its refresh latch.

## Interface
- PERIOD, 384: CLK cycles between refresh ticks, at 25 MHz with 15.36 µs spacing; ≥ 4.
- URG_WAIT, 256: cycles a refresh may stay pending before it goes urgent; 1 ≤ URG_WAIT < 2^AGE_W.
- URG_DEBT, 2: owed-refresh count at or above which urgency is immediate; 1 ≤ URG_DEBT ≤ MAX_DEBT.
- MAX_DEBT, 7: saturation limit of the owed-refresh counter.
- AGE_W, 9: age counter width.
- CLK  in  1: system clock, all logic on posedge.
- RST  in  1: synchronous, active-high reset.
- En  in  1: timer enable; when low, the timer holds and no new debt accrues; existing debt is still served.
- RefAck  in  1: one-cycle pulse from the RAM controller on the first refresh-RAS cycle.
- RefReqOut  out  1: refresh request, drives the controller RefReqIn; registered.
- RefUrgOut  out  1: urgent refresh, drives the controller RefUrgIn; registered; implies RefReqOut.
- Debt  out  3: current owed-refresh count.
- Overrun  out  1: sticky; set when a tick arrives with Debt == MAX_DEBT.

## Operation
- Timer: down-counter loaded with PERIOD-1. It decrements while En. At 0 with En it raises tick and reloads.
- Debt update, per cycle, from tick and valid ack (RefAck && Debt>0):
  - tick only: +1, saturating at MAX_DEBT. Saturated tick sets Overrun.
  - ack only: −1.
  - both: unchanged.
  - RefAck with Debt==0: ignored, no state change.
- Age: cleared when Debt==0 or on a valid ack. Otherwise increments, saturating at all-ones.
- FSM states are IDLE, REQ, URG, GAP. Transitions are evaluated on next-cycle values:
  - IDLE → REQ when next Debt>0. IDLE → URG directly if next Debt ≥ URG_DEBT.
  - REQ → URG when Age ≥ URG_WAIT-1 or next Debt ≥ URG_DEBT.
  - REQ/URG → GAP on a valid ack.
  - GAP lasts exactly one cycle. It then goes to IDLE if Debt==0, URG if Debt ≥ URG_DEBT, else REQ.
  - A tick during GAP is counted but does not shorten GAP.
- Outputs:
  - RefReqOut = state ∈ {REQ, URG}.
  - RefUrgOut = state == URG.
  - Both are low in GAP, which gives the controller the required request-low cycle between refreshes.
- Overrun clears only on RST.

## Timing
- Reset values: timer=PERIOD-1, Debt=0, Age=0, state IDLE, RefReqOut=0, RefUrgOut=0, Overrun=0.
- With En high from the first cycle after reset, the first tick is at cycle PERIOD after reset release. RefReqOut rises on the following edge (1-cycle latency).
- Ack-to-drop latency: RefReqOut falls on the edge after RefAck. It is low for exactly 1 cycle if debt remains.
- Escalation: with URG_DEBT > 1, RefUrgOut rises exactly URG_WAIT cycles after RefReqOut rises, if no ack arrives.
- RST asserted mid-pending drops both outputs on the next edge and discards the debt.

## Structure
- A shared package `ram_pkg` holds:
  - the state encoding enum (IDLE, REQ, URG, GAP);
  - default PERIOD/URG_WAIT constants.
- The controller uses the same refresh constants.
- One natural sub-module: `refresh_timer` (reloadable down-counter with enable and tick output).
- Debt, age and FSM stay in the top block.

## Test plan
- Test 1, reset and first tick. Stimulus: PERIOD=8, En=1, no ack. Required: tick at cycle 8; RefReqOut=1 from cycle 9; Debt=1.
- Test 2, ack and gap. Stimulus: Debt=2, pulse RefAck. Required: next cycle RefReqOut=0, Debt=1; the cycle after that RefReqOut=1 again.
- Test 3, age escalation. Stimulus: URG_WAIT=5, URG_DEBT=7, one pending, no ack. Required: RefUrgOut rises exactly 5 cycles after RefReqOut. Ack returns both outputs to 0 and the state to IDLE.
- Test 4, simultaneous tick and ack. Stimulus: Debt=1. Required: Debt stays 1 and the one-cycle GAP occurs.
- Test 5, saturation. Stimulus: never ack over 9 ticks. Required: Debt stops at 7, Overrun=1 on the 8th tick and stays set; spurious RefAck at Debt 0 ignored.
- Test 6, disable and mid-operation reset. Stimulus: En=0 for 20 cycles. Required: no tick while disabled. Stimulus: RST while in URG. Required: all outputs 0 next edge.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared refresh constants and scheduler state encoding, also used by the RAM controller.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    URG  = 2'd2,
    GAP  = 2'd3
  } ref_state_e;

  // 15.36 us refresh spacing at 25 MHz
  localparam int REF_PERIOD   = 384;
  localparam int REF_URG_WAIT = 256;
  localparam int REF_URG_DEBT = 2;
  localparam int REF_MAX_DEBT = 7;
  localparam int REF_AGE_W    = 9;
  localparam int REF_DEBT_W   = 3;

endpackage

// File: rtl/refresh_timer.sv
// Reloadable down-counter: emits a registered one-cycle tick every PERIOD enabled cycles.
module refresh_timer
  import ram_pkg::*;
#(
  parameter int PERIOD = REF_PERIOD
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Count down while enabled; hold when disabled; reload and tick on reaching zero.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (en_i) begin
      if (cnt_q == '0) begin
        cnt_d  = RELOAD;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= RELOAD;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/ram_refresh_sched.sv
// DRAM refresh scheduler: owed-refresh debt, age-based escalation and the
// REQ/URG/GAP handshake toward the RAM controller's refresh latch.
module ram_refresh_sched
  import ram_pkg::*;
#(
  parameter int PERIOD   = REF_PERIOD,
  parameter int URG_WAIT = REF_URG_WAIT,
  parameter int URG_DEBT = REF_URG_DEBT,
  parameter int MAX_DEBT = REF_MAX_DEBT,
  parameter int AGE_W    = REF_AGE_W
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       En,
  input  logic       RefAck,
  output logic       RefReqOut,
  output logic       RefUrgOut,
  output logic [2:0] Debt,
  output logic       Overrun
);

  localparam logic [2:0]       MAX_L  = 3'(MAX_DEBT);
  localparam logic [2:0]       URGD_L = 3'(URG_DEBT);
  localparam logic [AGE_W-1:0] WAIT_L = AGE_W'(URG_WAIT - 1);

  logic             tick;
  logic             ack_vld;
  logic [2:0]       debt_q, debt_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             ovr_q, ovr_d;
  logic             req_q, req_d;
  logic             urg_q, urg_d;
  ref_state_e       state_q, state_d;

  refresh_timer #(
    .PERIOD(PERIOD)
  ) u_timer (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (En),
    .tick_o(tick)
  );

  // An acknowledge only counts when something is actually owed.
  assign ack_vld = RefAck && (debt_q != 3'd0);

  // Debt bookkeeping: tick adds, ack retires, both together cancel; age tracks how long debt has waited.
  always_comb begin
    debt_d = debt_q;
    if (tick && !ack_vld) begin
      if (debt_q != MAX_L) debt_d = debt_q + 3'd1;
    end else if (ack_vld && !tick) begin
      debt_d = debt_q - 3'd1;
    end
    ovr_d = ovr_q | (tick && (debt_q == MAX_L));
    if ((debt_q == 3'd0) || ack_vld) begin
      age_d = '0;
    end else if (age_q != '1) begin
      age_d = age_q + 1'b1;
    end else begin
      age_d = age_q;
    end
  end

  // Next-state logic, looking at the post-update debt so requests follow ticks by one edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (debt_d >= URGD_L)     state_d = URG;
        else if (debt_d != 3'd0)  state_d = REQ;
      end
      REQ: begin
        if (ack_vld)                                 state_d = GAP;
        else if ((age_q >= WAIT_L) || (debt_d >= URGD_L)) state_d = URG;
      end
      URG: begin
        if (ack_vld) state_d = GAP;
      end
      GAP: begin
        if (debt_d == 3'd0)        state_d = IDLE;
        else if (debt_d >= URGD_L) state_d = URG;
        else                       state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the request pair leaves straight from flops.
  always_comb begin
    req_d = (state_d == REQ) || (state_d == URG);
    urg_d = (state_d == URG);
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      debt_q  <= 3'd0;
      age_q   <= '0;
      ovr_q   <= 1'b0;
      req_q   <= 1'b0;
      urg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      debt_q  <= debt_d;
      age_q   <= age_d;
      ovr_q   <= ovr_d;
      req_q   <= req_d;
      urg_q   <= urg_d;
    end
  end

  assign RefReqOut = req_q;
  assign RefUrgOut = urg_q;
  assign Debt      = debt_q;
  assign Overrun   = ovr_q;

endmodule

// File: tb/tb_ram_refresh_sched.sv
// Bench for ram_refresh_sched: fixed vectors, hand sequences for the corner cases,
// and randomized traffic checked against a cycle-level behavioural model.
module tb_ram_refresh_sched;

  localparam int P  = 8;
  localparam int UW = 5;
  localparam int UD = 3;
  localparam int MD = 7;
  localparam int AW = 9;

  logic       clk = 1'b0;
  logic       rst, en, ack;
  logic       req, urg, ovr;
  logic [2:0] debt;

  ram_refresh_sched #(
    .PERIOD(P), .URG_WAIT(UW), .URG_DEBT(UD), .MAX_DEBT(MD), .AGE_W(AW)
  ) dut (
    .CLK(clk), .RST(rst), .En(en), .RefAck(ack),
    .RefReqOut(req), .RefUrgOut(urg), .Debt(debt), .Overrun(ovr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: phase 0 idle, 1 requesting, 2 urgent, 3 request-low gap.
  int m_el, m_debt, m_age, m_ph;
  bit m_tick, m_ovr;

  task automatic model_edge(input bit r, input bit e, input bit a);
    bit vack, ntick;
    int nd, na, nph;
    if (r) begin
      m_el = 0; m_tick = 0; m_debt = 0; m_age = 0; m_ph = 0; m_ovr = 0;
      return;
    end
    vack = a && (m_debt > 0);
    nd = m_debt + (m_tick ? 1 : 0) - (vack ? 1 : 0);
    if (nd > MD) nd = MD;
    if (m_tick && m_debt == MD) m_ovr = 1;
    if (m_debt == 0 || vack) na = 0;
    else na = (m_age + 1 > (2**AW) - 1) ? (2**AW) - 1 : m_age + 1;
    nph = m_ph;
    case (m_ph)
      0: nph = (nd >= UD) ? 2 : (nd > 0) ? 1 : 0;
      1: nph = vack ? 3 : ((m_age >= UW - 1) || (nd >= UD)) ? 2 : 1;
      2: nph = vack ? 3 : 2;
      default: nph = (nd == 0) ? 0 : (nd >= UD) ? 2 : 1;
    endcase
    ntick = e && (m_el == P - 1);
    if (e) m_el = (m_el + 1) % P;
    m_tick = ntick; m_debt = nd; m_age = na; m_ph = nph;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, step the model on the edge, then compare after the edge.
  task automatic cyc(input bit r, input bit e, input bit a);
    rst = r; en = e; ack = a;
    @(posedge clk);
    model_edge(r, e, a);
    #1;
    check("mdl_req",  int'(req),  int'(m_ph == 1 || m_ph == 2));
    check("mdl_urg",  int'(urg),  int'(m_ph == 2));
    check("mdl_debt", int'(debt), m_debt);
    check("mdl_ovr",  int'(ovr),  int'(m_ovr));
  endtask

  typedef struct {
    bit en;
    bit ack;
    bit req;
    bit urg;
    int debt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int g;
    bit r, e, a;

    // First tick, age escalation, ack back to idle, next tick re-requests.
    for (int k = 1; k <= 14; k++)
      tbl[k-1] = '{en: 1'b1, ack: 1'b0, req: (k >= 9), urg: (k >= 14), debt: (k >= 9) ? 1 : 0};
    tbl[14] = '{en: 1'b1, ack: 1'b1, req: 1'b0, urg: 1'b0, debt: 0};
    tbl[15] = '{en: 1'b1, ack: 1'b0, req: 1'b0, urg: 1'b0, debt: 0};
    tbl[16] = '{en: 1'b1, ack: 1'b0, req: 1'b1, urg: 1'b0, debt: 1};

    rst = 1'b1; en = 1'b0; ack = 1'b0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("rst_req",  int'(req),  0);
    check("rst_urg",  int'(urg),  0);
    check("rst_debt", int'(debt), 0);
    check("rst_ovr",  int'(ovr),  0);

    for (int i = 0; i < 17; i++) begin
      cyc(0, tbl[i].en, tbl[i].ack);
      check($sformatf("tbl%0d_req", i + 1),  int'(req),  int'(tbl[i].req));
      check($sformatf("tbl%0d_urg", i + 1),  int'(urg),  int'(tbl[i].urg));
      check($sformatf("tbl%0d_debt", i + 1), int'(debt), tbl[i].debt);
    end

    // Ack with two owed: request drops for one cycle, one refresh remains.
    g = 0;
    while (m_debt < 2 && g < 30) begin cyc(0, 1, 0); g++; end
    check("t2_debt2", int'(debt), 2);
    cyc(0, 1, 1);
    check("t2_gap_req", int'(req), 0);
    check("t2_gap_debt", int'(debt), 1);
    cyc(0, 1, 0);
    check("t2_rearm_req", int'(req), 1);

    // Tick and ack in the same cycle: debt unchanged, gap still taken.
    g = 0;
    while (!(m_tick && m_debt == 1) && g < 30) begin cyc(0, 1, 0); g++; end
    check("t4_pre_debt", int'(debt), 1);
    cyc(0, 1, 1);
    check("t4_gap_req", int'(req), 0);
    check("t4_gap_urg", int'(urg), 0);
    check("t4_gap_debt", int'(debt), 1);
    cyc(0, 1, 0);
    check("t4_rearm_req", int'(req), 1);
    check("t4_rearm_debt", int'(debt), 1);

    // Disabled timer: no new debt accrues.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0);
      check("t6_hold_debt", int'(debt), 1);
    end

    // Saturation, with spurious acks at zero debt first.
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    check("t5_spur_debt", int'(debt), 0);
    check("t5_spur_req", int'(req), 0);
    cyc(0, 0, 1);
    check("t5_spur_debt2", int'(debt), 0);
    for (int k = 1; k <= 73; k++) begin
      cyc(0, 1, 0);
      if (k == 57) check("t5_debt7", int'(debt), 7);
      if (k == 64) check("t5_ovr_before", int'(ovr), 0);
      if (k == 65) check("t5_ovr_set", int'(ovr), 1);
    end
    check("t5_sat_debt", int'(debt), 7);
    check("t5_ovr_sticky", int'(ovr), 1);
    check("t5_urg", int'(urg), 1);

    // Reset while urgent.
    cyc(1, 1, 0);
    check("t6_rst_req",  int'(req),  0);
    check("t6_rst_urg",  int'(urg),  0);
    check("t6_rst_debt", int'(debt), 0);
    check("t6_rst_ovr",  int'(ovr),  0);

    // Randomized traffic against the model.
    cyc(0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 499) == 0);
      e = ($urandom_range(0, 9) != 0);
      if (m_ph == 1 || m_ph == 2) a = ($urandom_range(0, 3) == 0);
      else                        a = ($urandom_range(0, 15) == 0);
      cyc(r, e, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
